// File: rtl/proc_pkg.sv
// Shared definitions for the 8-bit register processor: instruction word layout and opcodes.
package proc_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    OP_MV  = 2'b00,
    OP_MVI = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } op_e;

  // Word layout: [7:6] op, [5:3] rX, [2:0] rY
  typedef struct packed {
    op_e        op;
    logic [2:0] rx;
    logic [2:0] ry;
  } instr_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPT,
    S_PRESENT,
    S_DONE
  } issue_state_e;

endpackage

// File: rtl/prog_issuer.sv
// Fetches words from a synchronous program ROM and issues them over valid/ready,
// keeping an mvi opcode and its immediate together; free-run, single-step and halt.
module prog_issuer
  import proc_pkg::*;
#(
  parameter int              ADDR_W    = 5,
  parameter int              DATA_W    = proc_pkg::DATA_W,
  parameter int              PROG_LEN  = 32,
  parameter bit              HALT_EN   = 1'b1,
  parameter logic [DATA_W-1:0] HALT_CODE = 8'hFF
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Run,
  input  logic              Step,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              is_imm,
  output logic [ADDR_W-1:0] pc,
  output logic              done
);

  issue_state_e      state, state_nx;
  logic              credit;
  logic              accept;
  logic              is_halt;
  logic              opc_mvi;
  logic [ADDR_W-1:0] pc_inc;

  assign accept   = dout_valid & dout_ready;
  // Only opcode words can halt; an immediate equal to HALT_CODE is plain data.
  assign is_halt  = HALT_EN && !is_imm && (rom_q == HALT_CODE);
  assign opc_mvi  = !is_imm && (op_e'(dout[DATA_W-1 -: 2]) == OP_MVI);
  assign pc_inc   = (pc == ADDR_W'(PROG_LEN - 1)) ? '0 : pc + 1'b1;
  assign rom_addr = pc;
  assign done     = (state == S_DONE);

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:    if (Run || credit || Step) state_nx = S_READ;
      S_READ:    state_nx = S_CAPT;
      S_CAPT:    state_nx = is_halt ? S_DONE : S_PRESENT;
      // A pending immediate is fetched regardless of Run so mvi stays atomic.
      S_PRESENT: if (accept) state_nx = (opc_mvi || Run) ? S_READ : S_IDLE;
      S_DONE:    state_nx = S_DONE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= S_IDLE;
      pc         <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      is_imm     <= 1'b0;
      credit     <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE) begin
        if (state_nx == S_READ) credit <= 1'b0;
      end else if (Step && !Run) begin
        credit <= 1'b1;
      end
      if (state == S_CAPT && !is_halt) begin
        dout       <= rom_q;
        dout_valid <= 1'b1;
      end
      if (state == S_PRESENT && accept) begin
        dout_valid <= 1'b0;
        pc         <= pc_inc;
        is_imm     <= opc_mvi;
      end
    end
  end

endmodule
